inst_axi_rd_bridge: RTL and testbench
=====================================

INST_AXI_RD_BRIDGE -- requirements
Module: inst_axi_rd_bridge

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 2, meaning the maximum number of accepted, not-yet-answered fetch requests (legal range 1..7).
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1); one clock; reset is synchronous and active-high.
REQ-003 SHALL have port inst_req_i (in, 1): IF-stage fetch request.
REQ-004 SHALL have port inst_addr_i (in, 32): physical fetch address, word aligned.
REQ-005 SHALL have port inst_cancel_i (in, 1): flush; drop all outstanding responses.
REQ-006 SHALL have port inst_addr_ok_o (out, 1): request accepted this cycle.
REQ-007 SHALL have ports inst_data_ok_o (out, 1), inst_rdata_o (out, 32) and inst_err_o (out, 1), forming the response.
REQ-008 SHALL have AXI AR ports: arid_o (out, 4), araddr_o (out, 32), arlen_o (out, 8), arsize_o (out, 3), arvalid_o (out, 1), arready_i (in, 1).
REQ-009 SHALL have AXI R ports: rid_i (in, 4), rdata_i (in, 32), rresp_i (in, 2), rlast_i (in, 1), rvalid_i (in, 1), rready_o (out, 1).

Function
REQ-010 SHALL drive constant arid_o=0, arlen_o=0 and arsize_o=3'b010, giving single-beat, in-order reads.
REQ-011 SHALL keep outst_cnt, incremented on inst_req_i&inst_addr_ok_o and decremented on rvalid_i&rready_o; if both occur in one cycle, outst_cnt is unchanged.
REQ-012 SHALL never assert inst_addr_ok_o when outst_cnt==MAX_OUTST, unless an R handshake occurs in the same cycle.
REQ-013 SHALL force inst_addr_ok_o=0 in any cycle with inst_cancel_i=1.
REQ-014 SHALL keep drop_cnt: on inst_cancel_i, drop_cnt is loaded with the next-cycle outstanding count, i.e. all in-flight requests excluding any R handshake occurring in the cancel cycle.
REQ-015 SHALL decrement drop_cnt (saturating at 0) on each R handshake while drop_cnt!=0, and suppress inst_data_ok_o for that beat.
REQ-016 SHALL suppress inst_data_ok_o for a beat arriving in the same cycle as inst_cancel_i.
REQ-017 SHALL produce a response combinationally from the R channel: inst_data_ok_o=rvalid_i&(drop_cnt==0)&~inst_cancel_i, inst_rdata_o=rdata_i, and inst_err_o=rresp_i[1] gated by data_ok.
REQ-018 SHALL drive rready_o=1 in every cycle after reset, because IF never back-pressures.
REQ-019 SHALL treat a cancel arriving while drop_cnt!=0 by reloading drop_cnt per REQ-014; earlier drops are subsumed.
REQ-020 SHALL never drop arvalid_o before arready_i once it is asserted, cancel included; the resulting response is discarded via drop_cnt.

Reset
REQ-021 SHALL clear outst_cnt, drop_cnt and the AR register (if present) while rst=1.
REQ-022 SHALL hold arvalid_o=0, rready_o=0, inst_addr_ok_o=0 and inst_data_ok_o=0 while rst=1.
REQ-023 SHALL, when reset is asserted mid-transaction, abandon pending state; the interconnect is reset together.

Configuration
REQ-024 SHALL support macro INST_AR_PIPE_EN, which registers the AR channel.
REQ-025 SHALL, when INST_AR_PIPE_EN is defined: set addr_ok=(~arvalid_q|arready_i)&count-limit; on accept, load araddr_q and set arvalid_q=1; clear arvalid_q on a handshake without a new accept. ARVALID appears 1 cycle after addr_ok.
REQ-026 SHALL, when INST_AR_PIPE_EN is not defined: drive arvalid_o=inst_req_i&~inst_cancel_i&count-limit, araddr_o=inst_addr_i and inst_addr_ok_o=arvalid_o&arready_i, with zero added latency.

Structure
REQ-027 SHALL take the AXI size/len/id constants and MAX_OUTST default from the shared CPU define header, also used by the data-side bridge.
REQ-028 SHALL use one sub-module, inst_drop_ctr, holding outst_cnt/drop_cnt logic; AR-path logic stays in the top.

Verification
REQ-029 SHALL cover: req addr 0x1c000000, arready=1, R data 0x02c00000 two cycles later -> addr_ok same cycle (no macro) or ARVALID next cycle (macro), then data_ok=1 with rdata 0x02c00000.
REQ-030 SHALL cover: three back-to-back reqs with MAX_OUTST=2 and no R -> third addr_ok=0 until the first R beat.
REQ-031 SHALL cover: two outstanding, cancel, then two R beats, then a new req at 0x1c000100 -> no data_ok for the old beats; new data_ok returns its data.
REQ-032 SHALL cover: cancel in the same cycle as an R beat with one other outstanding -> that beat dropped, drop_cnt=1, next beat dropped.
REQ-033 SHALL cover: rresp=2'b10 on an undropped beat -> data_ok=1, err=1.
REQ-034 SHALL cover: rst asserted with arvalid=1 (macro) -> next cycle arvalid=0, counters 0, rready=0 until rst=0.

Source files
------------

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared CPU-side AXI read constants and helpers, used by both the instruction and data bridges.
// Counter width covers the full legal outstanding range of 1..7.
package inst_axi_rd_bridge_pkg;

   localparam int unsigned INST_MAX_OUTST_DEF = 2;
   localparam int unsigned CNT_W              = 3;

   localparam logic [3:0] AXI_INST_ARID    = 4'd0;
   localparam logic [7:0] AXI_ARLEN_SINGLE = 8'd0;
   localparam logic [2:0] AXI_ARSIZE_WORD  = 3'b010;

   // Bit 1 of RRESP set means SLVERR or DECERR.
   localparam int unsigned AXI_RESP_ERR_BIT = 1;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ar_req_t;

   function automatic cnt_t cnt_next(input cnt_t c, input logic inc, input logic dec);
      return c + cnt_t'(inc) - cnt_t'(dec);
   endfunction

endpackage

// File: rtl/inst_drop_ctr.sv
// Tracks accepted-but-unanswered fetches and how many in-flight beats must be discarded after a flush.
module inst_drop_ctr
   import inst_axi_rd_bridge_pkg::*;
#(
   parameter int unsigned MAX_OUTST = INST_MAX_OUTST_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_accept,
   input  logic i_r_hs,
   input  logic i_cancel,
   output logic o_can_accept,
   output logic o_drop_active
);

   localparam cnt_t LIMIT = cnt_t'(MAX_OUTST);

   cnt_t r_outst_cnt;
   cnt_t r_drop_cnt;
   cnt_t w_outst_nxt;
   cnt_t w_drop_nxt;

   always_comb begin
      w_outst_nxt = cnt_next(r_outst_cnt, i_accept, i_r_hs);
   end

   // A flush marks everything still in flight next cycle, replacing any earlier drop count.
   always_comb begin
      w_drop_nxt = r_drop_cnt;
      if (i_cancel) begin
         w_drop_nxt = w_outst_nxt;
      end else if (i_r_hs && (r_drop_cnt != '0)) begin
         w_drop_nxt = r_drop_cnt - cnt_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outst_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_outst_cnt <= w_outst_nxt;
         r_drop_cnt  <= w_drop_nxt;
      end
   end

   // A beat retiring this cycle frees a slot for a same-cycle accept.
   always_comb begin
      o_can_accept  = (r_outst_cnt != LIMIT) | i_r_hs;
      o_drop_active = (r_drop_cnt != '0);
   end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch to AXI read bridge: single-beat in-order reads with flush support.
// Define INST_AR_PIPE_EN to register the AR channel (one extra cycle of AR latency).
module inst_axi_rd_bridge
   import inst_axi_rd_bridge_pkg::*;
#(
   parameter int unsigned MAX_OUTST = INST_MAX_OUTST_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req_i,
   input  logic [31:0] inst_addr_i,
   input  logic        inst_cancel_i,
   output logic        inst_addr_ok_o,
   output logic        inst_data_ok_o,
   output logic [31:0] inst_rdata_o,
   output logic        inst_err_o,
   output logic [3:0]  arid_o,
   output logic [31:0] araddr_o,
   output logic [7:0]  arlen_o,
   output logic [2:0]  arsize_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [3:0]  rid_i,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   input  logic        rlast_i,
   input  logic        rvalid_i,
   output logic        rready_o
);

   logic w_rready;
   logic w_r_hs;
   logic w_addr_ok;
   logic w_accept;
   logic w_can_accept;
   logic w_drop_active;
   logic w_data_ok;
   logic w_unused;

   // Reads are single-beat and in-order, so ID and LAST carry no information.
   assign w_unused = ^{rid_i, rlast_i, rresp_i[0]};

   assign w_rready = ~rst;
   assign w_r_hs   = rvalid_i & w_rready;
   assign w_accept = inst_req_i & w_addr_ok;

   inst_drop_ctr #(
      .MAX_OUTST (MAX_OUTST)
   ) u_drop_ctr (
      .clk           (clk),
      .rst           (rst),
      .i_accept      (w_accept),
      .i_r_hs        (w_r_hs),
      .i_cancel      (inst_cancel_i),
      .o_can_accept  (w_can_accept),
      .o_drop_active (w_drop_active)
   );

`ifdef INST_AR_PIPE_EN
   ar_req_t r_ar;

   // Once raised, ARVALID holds until ARREADY even across a flush; the answer is dropped later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ar <= '0;
      end else if (w_accept) begin
         r_ar.valid <= 1'b1;
         r_ar.addr  <= inst_addr_i;
      end else if (arready_i) begin
         r_ar.valid <= 1'b0;
      end
   end

   always_comb begin
      w_addr_ok = ~rst & ~inst_cancel_i & (~r_ar.valid | arready_i) & w_can_accept;
      arvalid_o = r_ar.valid & ~rst;
      araddr_o  = r_ar.addr;
   end
`else
   logic w_arvalid;

   always_comb begin
      w_arvalid = ~rst & inst_req_i & ~inst_cancel_i & w_can_accept;
      arvalid_o = w_arvalid;
      araddr_o  = inst_addr_i;
      w_addr_ok = w_arvalid & arready_i;
   end
`endif

   // Beats owed to a flushed fetch, or landing in the flush cycle itself, never reach IF.
   always_comb begin
      w_data_ok      = ~rst & rvalid_i & ~w_drop_active & ~inst_cancel_i;
      inst_addr_ok_o = w_addr_ok;
      inst_data_ok_o = w_data_ok;
      inst_rdata_o   = rdata_i;
      inst_err_o     = w_data_ok & rresp_i[AXI_RESP_ERR_BIT];
      rready_o       = w_rready;
      arid_o         = AXI_INST_ARID;
      arlen_o        = AXI_ARLEN_SINGLE;
      arsize_o       = AXI_ARSIZE_WORD;
   end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: directed scenarios plus randomized traffic against a queue model.
// Honours INST_AR_PIPE_EN the same way the design does.
module tb_inst_axi_rd_bridge;

   localparam int unsigned MAX = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req_i;
   logic [31:0] inst_addr_i;
   logic        inst_cancel_i;
   logic        inst_addr_ok_o;
   logic        inst_data_ok_o;
   logic [31:0] inst_rdata_o;
   logic        inst_err_o;
   logic [3:0]  arid_o;
   logic [31:0] araddr_o;
   logic [7:0]  arlen_o;
   logic [2:0]  arsize_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [3:0]  rid_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rlast_i;
   logic        rvalid_i;
   logic        rready_o;

   int nVectors = 0;
   int nMiss    = 0;

   // Model: fetches accepted but unanswered (with a flushed flag), and reads the slave owes.
   logic [31:0] addrQ[$];
   bit          dropQ[$];
   logic [31:0] slaveQ[$];
   bit          pend = 1'b0;
   logic [31:0] pendAddr = '0;

   logic        obsAddrOk, obsArvalid, obsDataOk, obsErr, obsRready;
   logic [31:0] obsRdata, obsAraddr;

   always #5 clk = ~clk;

   inst_axi_rd_bridge #(
      .MAX_OUTST (MAX)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .inst_req_i     (inst_req_i),
      .inst_addr_i    (inst_addr_i),
      .inst_cancel_i  (inst_cancel_i),
      .inst_addr_ok_o (inst_addr_ok_o),
      .inst_data_ok_o (inst_data_ok_o),
      .inst_rdata_o   (inst_rdata_o),
      .inst_err_o     (inst_err_o),
      .arid_o         (arid_o),
      .araddr_o       (araddr_o),
      .arlen_o        (arlen_o),
      .arsize_o       (arsize_o),
      .arvalid_o      (arvalid_o),
      .arready_i      (arready_i),
      .rid_i          (rid_i),
      .rdata_i        (rdata_i),
      .rresp_i        (rresp_i),
      .rlast_i        (rlast_i),
      .rvalid_i       (rvalid_i),
      .rready_o       (rready_o)
   );

   function automatic logic [31:0] dataFor(input logic [31:0] a);
      if (a == 32'h1c000000) return 32'h02c00000;
      return {a[15:0], a[31:16]} ^ 32'h12345678;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, compare against the model just after, advance the model at posedge.
   task automatic applyStimulus(input bit rstV, input bit reqV, input logic [31:0] addrV,
                                input bit cancelV, input bit arreadyV, input bit rvalidV,
                                input logic [1:0] rrespV);
      bit          expRready, hs, limitOk, expAddrOk, expArvalid, expDataOk, acc;
      logic [31:0] expAraddr;
      @(negedge clk);
      rst           = rstV;
      inst_req_i    = reqV;
      inst_addr_i   = addrV;
      inst_cancel_i = cancelV;
      arready_i     = arreadyV;
      rvalid_i      = rvalidV && (slaveQ.size() > 0);
      rdata_i       = (slaveQ.size() > 0) ? dataFor(slaveQ[0]) : $urandom;
      rresp_i       = rrespV;
      rid_i         = 4'd0;
      rlast_i       = 1'b1;
      #1;
      expRready = !rstV;
      hs        = rvalid_i && !rstV;
      limitOk   = (addrQ.size() < MAX) || hs;
`ifdef INST_AR_PIPE_EN
      expAddrOk  = !rstV && !cancelV && (!pend || arreadyV) && limitOk;
      expArvalid = pend && !rstV;
      expAraddr  = pendAddr;
`else
      expArvalid = !rstV && reqV && !cancelV && limitOk;
      expAddrOk  = expArvalid && arreadyV;
      expAraddr  = addrV;
`endif
      acc       = reqV && expAddrOk;
      expDataOk = !rstV && rvalid_i && !cancelV && (addrQ.size() > 0) && !dropQ[0];

      obsAddrOk  = inst_addr_ok_o;
      obsArvalid = arvalid_o;
      obsAraddr  = araddr_o;
      obsDataOk  = inst_data_ok_o;
      obsRdata   = inst_rdata_o;
      obsErr     = inst_err_o;
      obsRready  = rready_o;

      checkOutput("rready", {31'd0, rready_o}, {31'd0, expRready});
      checkOutput("addr_ok", {31'd0, inst_addr_ok_o}, {31'd0, expAddrOk});
      checkOutput("arvalid", {31'd0, arvalid_o}, {31'd0, expArvalid});
      if (expArvalid) checkOutput("araddr", araddr_o, expAraddr);
      checkOutput("ar_consts", {17'd0, arid_o, arlen_o, arsize_o}, {17'd0, 4'd0, 8'd0, 3'b010});
      checkOutput("data_ok", {31'd0, inst_data_ok_o}, {31'd0, expDataOk});
      if (expDataOk) begin
         checkOutput("rdata", inst_rdata_o, dataFor(addrQ[0]));
         checkOutput("err", {31'd0, inst_err_o}, {31'd0, rrespV[1]});
      end else begin
         checkOutput("err_gated", {31'd0, inst_err_o}, 32'd0);
      end

      @(posedge clk);
      if (rstV) begin
         addrQ.delete();
         dropQ.delete();
         slaveQ.delete();
         pend = 1'b0;
      end else begin
         if (hs) begin
            void'(slaveQ.pop_front());
            void'(addrQ.pop_front());
            void'(dropQ.pop_front());
         end
`ifdef INST_AR_PIPE_EN
         if (pend && arreadyV) slaveQ.push_back(pendAddr);
         if (acc) begin
            pend     = 1'b1;
            pendAddr = addrV;
         end else if (arreadyV) begin
            pend = 1'b0;
         end
`else
         if (acc) slaveQ.push_back(addrV);
`endif
         if (cancelV) foreach (dropQ[i]) dropQ[i] = 1'b1;
         if (acc) begin
            addrQ.push_back(addrV);
            dropQ.push_back(1'b0);
         end
      end
   endtask

   initial begin
      logic [31:0] rAddr;
      rst = 1'b1; inst_req_i = 1'b0; inst_addr_i = '0; inst_cancel_i = 1'b0;
      arready_i = 1'b0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 32'h1c000000, 0, 1, 0, 2'b00);
         checkOutput("rst_addr_ok", {31'd0, obsAddrOk}, 32'd0);
         checkOutput("rst_arvalid", {31'd0, obsArvalid}, 32'd0);
         checkOutput("rst_rready", {31'd0, obsRready}, 32'd0);
         checkOutput("rst_data_ok", {31'd0, obsDataOk}, 32'd0);
      end

      // Single fetch with a response two cycles later.
      applyStimulus(0, 1, 32'h1c000000, 0, 1, 0, 2'b00);
      checkOutput("t029_addr_ok", {31'd0, obsAddrOk}, 32'd1);
`ifdef INST_AR_PIPE_EN
      checkOutput("t029_arvalid_a", {31'd0, obsArvalid}, 32'd0);
`else
      checkOutput("t029_arvalid_a", {31'd0, obsArvalid}, 32'd1);
`endif
      applyStimulus(0, 0, 32'h0, 0, 1, 0, 2'b00);
`ifdef INST_AR_PIPE_EN
      checkOutput("t029_arvalid_b", {31'd0, obsArvalid}, 32'd1);
      checkOutput("t029_araddr", obsAraddr, 32'h1c000000);
`endif
      applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b00);
      checkOutput("t029_data_ok", {31'd0, obsDataOk}, 32'd1);
      checkOutput("t029_rdata", obsRdata, 32'h02c00000);

      // Outstanding limit, relieved by a same-cycle R beat.
      applyStimulus(0, 1, 32'h1c000010, 0, 1, 0, 2'b00);
      checkOutput("t030_req1", {31'd0, obsAddrOk}, 32'd1);
      applyStimulus(0, 1, 32'h1c000014, 0, 1, 0, 2'b00);
      checkOutput("t030_req2", {31'd0, obsAddrOk}, 32'd1);
      applyStimulus(0, 1, 32'h1c000018, 0, 1, 0, 2'b00);
      checkOutput("t030_req3_blocked", {31'd0, obsAddrOk}, 32'd0);
      applyStimulus(0, 1, 32'h1c000018, 0, 1, 1, 2'b00);
      checkOutput("t030_req3_with_r", {31'd0, obsAddrOk}, 32'd1);
      checkOutput("t030_first_data", {31'd0, obsDataOk}, 32'd1);
      repeat (6) applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b00);

      // Flush with two in flight, then a fresh fetch.
      applyStimulus(0, 1, 32'h1c000200, 0, 1, 0, 2'b00);
      applyStimulus(0, 1, 32'h1c000204, 0, 1, 0, 2'b00);
      applyStimulus(0, 1, 32'h1c000300, 1, 1, 0, 2'b00);
      checkOutput("t031_cancel_addr_ok", {31'd0, obsAddrOk}, 32'd0);
      applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b00);
      checkOutput("t031_drop1", {31'd0, obsDataOk}, 32'd0);
      applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b00);
      checkOutput("t031_drop2", {31'd0, obsDataOk}, 32'd0);
      applyStimulus(0, 1, 32'h1c000100, 0, 1, 0, 2'b00);
      checkOutput("t031_new_addr_ok", {31'd0, obsAddrOk}, 32'd1);
      applyStimulus(0, 0, 32'h0, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b00);
      checkOutput("t031_new_data_ok", {31'd0, obsDataOk}, 32'd1);
      checkOutput("t031_new_rdata", obsRdata, 32'h13344a78);

      // Flush coinciding with an R beat, one more still in flight.
      applyStimulus(0, 1, 32'h1c000400, 0, 1, 0, 2'b00);
      applyStimulus(0, 1, 32'h1c000404, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 1, 1, 1, 2'b00);
      checkOutput("t032_cancel_beat", {31'd0, obsDataOk}, 32'd0);
      applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b00);
      checkOutput("t032_next_beat", {31'd0, obsDataOk}, 32'd0);
      applyStimulus(0, 1, 32'h1c000408, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b00);
      checkOutput("t032_after", {31'd0, obsDataOk}, 32'd1);

      // Error response.
      applyStimulus(0, 1, 32'h1c000500, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 1, 1, 2'b10);
      checkOutput("t033_data_ok", {31'd0, obsDataOk}, 32'd1);
      checkOutput("t033_err", {31'd0, obsErr}, 32'd1);

      // Reset while an AR is waiting for ARREADY.
      applyStimulus(0, 1, 32'h1c000600, 0, 0, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'b00);
`ifdef INST_AR_PIPE_EN
      checkOutput("t034_arvalid_held", {31'd0, obsArvalid}, 32'd1);
`endif
      repeat (2) begin
         applyStimulus(1, 0, 32'h0, 0, 0, 0, 2'b00);
         checkOutput("t034_rst_arvalid", {31'd0, obsArvalid}, 32'd0);
         checkOutput("t034_rst_rready", {31'd0, obsRready}, 32'd0);
      end
      applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'b00);
      checkOutput("t034_post_arvalid", {31'd0, obsArvalid}, 32'd0);
      checkOutput("t034_post_rready", {31'd0, obsRready}, 32'd1);

      for (int i = 0; i < 3000; i++) begin
         rAddr = $urandom;
         rAddr[1:0] = 2'b00;
         applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, rAddr,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
                       $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule
